// File: rtl/sccb_table_sequencer_if.sv
// sccb_table_sequencer_if: request/response bus between the table sequencer and the SCCB (i2c_control) master
//   master modport: sequencer side (drives requests, address, data; receives rddata/rw_done/ack)
//   slave modport : SCCB master side
//   ack = 1 means the slave NACKed; it is meaningful only while rw_done is high
interface sccb_table_sequencer_if;
  logic       wrreg_req;
  logic       rdreg_req;
  logic [15:0] reg_addr;
  logic       addr_mode;
  logic [7:0] wrdata;
  logic [7:0] device_id;
  logic [7:0] rddata;
  logic       rw_done;
  logic       ack;
  modport master(output wrreg_req, rdreg_req, reg_addr, addr_mode, wrdata, device_id, input rddata, rw_done, ack);
  modport slave(input wrreg_req, rdreg_req, reg_addr, addr_mode, wrdata, device_id, output rddata, rw_done, ack);
endinterface

// File: rtl/sccb_table_sequencer.sv
// sccb_table_sequencer: camera power-up sequencing, then walks a register table through the SCCB master
//   clk, rst            : clock, synchronous active-high reset
//   i_start             : one-cycle pulse, (re)starts the full sequence from any state
//   o_tbl_addr/i_tbl_data : external table ROM, data {reg_addr[15:0], value[7:0]} one cycle after address
//   bus                 : request/response bus to the SCCB master
//   o_camera_pwdn/o_camera_rst_n : sensor power-down and active-low reset
//   o_busy/o_init_done/o_init_err/o_err_index : sequence status
module sccb_table_sequencer #(
  parameter logic [7:0] DEVICE_ID = 8'h42,
  parameter int ADDR_16BIT = 0,
  parameter int TBL_DEPTH = 256,
  parameter int PWR_CYCLES = 65535,
  parameter int BOOT_CYCLES = 65535,
  parameter int DELAY_UNIT = 50000,
  parameter int MAX_RETRY = 3,
  parameter int VERIFY = 0,
  localparam int TBL_AW = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic [TBL_AW-1:0]     o_tbl_addr,
  input  logic [23:0]           i_tbl_data,
  sccb_table_sequencer_if.master bus,
  output logic                  o_camera_pwdn,
  output logic                  o_camera_rst_n,
  output logic                  o_busy,
  output logic                  o_init_done,
  output logic                  o_init_err,
  output logic [TBL_AW-1:0]     o_err_index
);
  localparam int DLY_MAX = 255 * DELAY_UNIT;
  localparam int PB_MAX = (PWR_CYCLES > BOOT_CYCLES) ? PWR_CYCLES : BOOT_CYCLES;
  localparam int CNT_MAX = (PB_MAX > DLY_MAX) ? PB_MAX : DLY_MAX;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_RST, S_BOOT, S_FETCH, S_DECODE, S_WR, S_WRW, S_RD, S_RDW, S_DLY, S_NEXT, S_DONE, S_ERR
  } state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_load;
  logic [RW-1:0] r_retry;
  logic [TBL_AW-1:0] r_tbl_addr, r_err_index;
  logic [15:0] r_reg_addr;
  logic [7:0] r_wrdata;
  logic r_busy, r_done, r_err;
  logic [15:0] w_key;
  logic [7:0] w_val;
  logic w_cnt_end, w_retry, w_last, w_rd_bad, w_enter;
  assign w_key = i_tbl_data[23:8];
  assign w_val = i_tbl_data[7:0];
  // down-counter reloaded on every state entry; <=1 also ends a zero-length load after one cycle
  assign w_cnt_end = r_cnt <= CW'(1);
  assign w_retry = r_retry < RW'(MAX_RETRY);
  assign w_last = r_tbl_addr == TBL_AW'(TBL_DEPTH - 1);
  assign w_rd_bad = bus.ack || bus.rddata != r_wrdata;
  // a Start while already in PWR must still reload the power-down timer
  assign w_enter = i_start || w_next != r_state;
  assign w_load = (w_next == S_DLY) ? CW'(DELAY_UNIT) * CW'(w_val) : (w_next == S_BOOT) ? CW'(BOOT_CYCLES) : CW'(PWR_CYCLES);
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (i_start) w_next = S_PWR;
    else case (r_state)
      S_PWR:    w_next = w_cnt_end ? S_RST : S_PWR;
      S_RST:    w_next = w_cnt_end ? S_BOOT : S_RST;
      S_BOOT:   w_next = w_cnt_end ? S_FETCH : S_BOOT;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = (w_key == 16'hFFFF) ? ((w_val == 8'd0) ? S_NEXT : S_DLY) : (w_key == 16'hFFFE) ? S_DONE : S_WR;
      S_WR:     w_next = S_WRW;
      S_WRW:    w_next = !bus.rw_done ? S_WRW : bus.ack ? (w_retry ? S_WR : S_ERR) : (VERIFY != 0) ? S_RD : S_NEXT;
      S_RD:     w_next = S_RDW;
      S_RDW:    w_next = !bus.rw_done ? S_RDW : w_rd_bad ? (w_retry ? S_WR : S_ERR) : S_NEXT;
      S_DLY:    w_next = w_cnt_end ? S_NEXT : S_DLY;
      S_NEXT:   w_next = w_last ? S_DONE : S_FETCH;
      default:  w_next = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_retry <= '0;
      r_tbl_addr <= '0;
      r_reg_addr <= '0;
      r_wrdata <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_err_index <= '0;
    end else begin
      r_cnt <= w_enter ? w_load : r_cnt - CW'(r_cnt != '0);
      r_retry <= (i_start || r_state == S_FETCH) ? '0 : (w_next == S_WR && (r_state == S_WRW || r_state == S_RDW)) ? r_retry + 1'b1 : r_retry;
      r_tbl_addr <= i_start ? '0 : (r_state == S_NEXT && !w_last) ? r_tbl_addr + 1'b1 : r_tbl_addr;
      if (r_state == S_DECODE && w_next == S_WR) begin
        r_reg_addr <= (ADDR_16BIT != 0) ? w_key : {8'h00, w_key[7:0]};
        r_wrdata <= w_val;
      end
      r_busy <= !(w_next inside {S_IDLE, S_DONE, S_ERR});
      r_done <= w_next == S_DONE;
      r_err <= w_next == S_ERR;
      if (w_next == S_ERR && r_state != S_ERR) r_err_index <= r_tbl_addr;
    end
  end
  assign o_tbl_addr = r_tbl_addr;
  assign o_camera_pwdn = r_state inside {S_IDLE, S_PWR};
  assign o_camera_rst_n = !(r_state inside {S_IDLE, S_PWR, S_RST});
  assign o_busy = r_busy;
  assign o_init_done = r_done;
  assign o_init_err = r_err;
  assign o_err_index = r_err_index;
  assign bus.wrreg_req = r_state == S_WR;
  assign bus.rdreg_req = r_state == S_RD;
  assign bus.reg_addr = r_reg_addr;
  assign bus.addr_mode = ADDR_16BIT != 0;
  assign bus.wrdata = r_wrdata;
  assign bus.device_id = DEVICE_ID;
endmodule

// File: tb/tb_sccb_table_sequencer.sv
// tb_sccb_table_sequencer: directed bench; instance 0 is 8-bit/no-verify, instance 1 is 16-bit/verify
module tb_sccb_table_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int failures = 0;
  logic start[2];
  logic [23:0] rom[2][16];
  int lat[2];
  int nack_lim[2];
  logic [7:0] rd_xor[2];
  logic [15:0] nack_addr[2];
  logic [3:0] taddr[2], erri[2];
  logic pwdn[2], rstn[2], busy[2], done[2], err[2], wreq[2], am[2];
  logic [15:0] raddr[2], laddr[2];
  logic [7:0] wdat[2], dev[2], ldat[2];
  int wcnt[2], rcnt[2], ncnt[2], pfall[2], rrise[2], lastw[2], gap[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sccb_table_sequencer_if bus();
    logic [23:0] td;
    logic [7:0] m_wd;
    logic [15:0] m_wa;
    logic m_rd;
    int pend;
    logic prev_pw = 1'b1;
    logic prev_rn = 1'b0;
    int wc = 0, rc = 0, nk = 0, pf = 0, rr = 0, lw = 0, gp = 0;
    logic [15:0] la = '0;
    logic [7:0] ld = '0;
    sccb_table_sequencer #(
      .DEVICE_ID(8'h42), .ADDR_16BIT(g), .TBL_DEPTH(16), .PWR_CYCLES(20), .BOOT_CYCLES(20),
      .DELAY_UNIT(10), .MAX_RETRY(3), .VERIFY(g)
    ) dut (
      .clk(clk), .rst(rst), .i_start(start[g]), .o_tbl_addr(taddr[g]), .i_tbl_data(td), .bus(bus),
      .o_camera_pwdn(pwdn[g]), .o_camera_rst_n(rstn[g]), .o_busy(busy[g]), .o_init_done(done[g]),
      .o_init_err(err[g]), .o_err_index(erri[g])
    );
    assign wreq[g] = bus.wrreg_req;
    assign raddr[g] = bus.reg_addr;
    assign wdat[g] = bus.wrdata;
    assign am[g] = bus.addr_mode;
    assign dev[g] = bus.device_id;
    assign wcnt[g] = wc;
    assign rcnt[g] = rc;
    assign ncnt[g] = nk;
    assign pfall[g] = pf;
    assign rrise[g] = rr;
    assign lastw[g] = lw;
    assign gap[g] = gp;
    assign laddr[g] = la;
    assign ldat[g] = ld;
    // ROM with one-cycle latency and an SCCB master model answering lat[g] cycles after a request
    always @(posedge clk) begin
      td <= rom[g][taddr[g]];
      bus.rw_done <= 1'b0;
      if (rst) begin
        pend <= 0;
        m_rd <= 1'b0;
        m_wa <= '0;
        m_wd <= '0;
        bus.ack <= 1'b0;
        bus.rddata <= '0;
      end else if (bus.wrreg_req || bus.rdreg_req) begin
        pend <= lat[g];
        m_rd <= bus.rdreg_req;
        if (bus.wrreg_req) begin
          m_wa <= bus.reg_addr;
          m_wd <= bus.wrdata;
        end
      end else if (pend > 0) begin
        pend <= pend - 1;
        if (pend == 1) begin
          bus.rw_done <= 1'b1;
          bus.ack <= !m_rd && m_wa == nack_addr[g] && nk < nack_lim[g];
          if (!m_rd && m_wa == nack_addr[g] && nk < nack_lim[g]) nk <= nk + 1;
          bus.rddata <= m_wd ^ rd_xor[g];
        end
      end
    end
    always @(negedge clk) begin
      if (prev_pw && !pwdn[g]) pf <= cyc;
      if (!prev_rn && rstn[g]) rr <= cyc;
      prev_pw <= pwdn[g];
      prev_rn <= rstn[g];
      if (bus.wrreg_req) begin
        wc <= wc + 1;
        gp <= cyc - lw;
        lw <= cyc;
        la <= bus.reg_addr;
        ld <= bus.wrdata;
      end
      if (bus.rdreg_req) rc <= rc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int g, output int s);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    s = cyc;
  endtask

  task automatic wait_first(input int g, input int w0, output int fw);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (wcnt[g] != w0) break;
    end
    check("first_wr_seen", wcnt[g] != w0, 1);
    fw = lastw[g];
  endtask

  task automatic wait_idle(input int g);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (!busy[g]) break;
    end
    check("idle_timeout", busy[g], 0);
    @(negedge clk);
  endtask

  initial begin
    int s, w0, r0, n0, fw;
    start = '{1'b0, 1'b0};
    lat = '{3, 3};
    rd_xor = '{8'h00, 8'h00};
    nack_addr = '{16'h00AA, 16'h00AA};
    nack_lim = '{0, 0};
    for (int g = 0; g < 2; g++) for (int i = 0; i < 16; i++) rom[g][i] = 24'hFFFE00;
    repeat (2) @(negedge clk);
    start[0] = 1'b1;
    start[1] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    start[1] = 1'b0;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_pwdn", pwdn[g], 1);
      check("rst_rstn", rstn[g], 0);
      check("rst_busy", busy[g], 0);
      check("rst_done", done[g], 0);
      check("rst_err", err[g], 0);
      check("rst_erri", erri[g], 0);
      check("rst_taddr", taddr[g], 0);
      check("rst_wreq", wreq[g], 0);
      check("rst_raddr", raddr[g], 0);
      check("rst_wdat", wdat[g], 0);
      check("rst_wcnt", wcnt[g], 0);
    end

    rom[0][0] = 24'h001280; rom[0][1] = 24'hFFFF02; rom[0][2] = 24'h001101; rom[0][3] = 24'hFFFE00;
    w0 = wcnt[0];
    pulse(0, s);
    wait_first(0, w0, fw);
    check("t1_first_wr", fw - s, 62);
    wait_idle(0);
    check("t1_pwdn_fall", pfall[0] - s, 20);
    check("t1_rstn_rise", rrise[0] - s, 40);
    check("t1_writes", wcnt[0] - w0, 2);
    check("t1_gap_delay", gap[0] >= 26 && gap[0] <= 36, 1);
    check("t1_last_addr", laddr[0], 16'h0011);
    check("t1_last_data", ldat[0], 8'h01);
    check("t1_done", done[0], 1);
    check("t1_err", err[0], 0);
    check("t1_pwdn", pwdn[0], 0);
    check("t1_rstn", rstn[0], 1);
    check("t1_addr_mode", am[0], 0);
    check("t1_dev_id", dev[0], 8'h42);

    rom[0][0] = 24'h001280; rom[0][1] = 24'h001355; rom[0][2] = 24'hFFFE00;
    n0 = ncnt[0];
    nack_addr[0] = 16'h0013;
    nack_lim[0] = n0 + 2;
    w0 = wcnt[0];
    pulse(0, s);
    wait_idle(0);
    check("t2_writes", wcnt[0] - w0, 4);
    check("t2_nacks", ncnt[0] - n0, 2);
    check("t2_done", done[0], 1);
    check("t2_err", err[0], 0);

    rom[0][2] = 24'h001499; rom[0][3] = 24'hFFFE00;
    nack_addr[0] = 16'h0014;
    nack_lim[0] = ncnt[0] + 100;
    w0 = wcnt[0];
    pulse(0, s);
    wait_idle(0);
    check("t3_writes", wcnt[0] - w0, 6);
    check("t3_err", err[0], 1);
    check("t3_err_index", erri[0], 2);
    check("t3_done", done[0], 0);
    check("t3_busy", busy[0], 0);
    repeat (50) @(negedge clk);
    check("t3_no_more_wr", wcnt[0] - w0, 6);
    nack_addr[0] = 16'h00AA;

    rom[0][0] = 24'h300882; rom[0][1] = 24'hFFFE00;
    w0 = wcnt[0];
    pulse(0, s);
    wait_idle(0);
    check("t4_writes", wcnt[0] - w0, 1);
    check("t4_addr8", laddr[0], 16'h0008);
    check("t4_data8", ldat[0], 8'h82);
    check("t4_reg_addr8", raddr[0], 16'h0008);
    check("t4_done", done[0], 1);
    check("t4_err_clr", err[0], 0);

    rom[1][0] = 24'h300882; rom[1][1] = 24'hFFFE00;
    w0 = wcnt[1];
    r0 = rcnt[1];
    pulse(1, s);
    wait_idle(1);
    check("t5_writes", wcnt[1] - w0, 1);
    check("t5_reads", rcnt[1] - r0, 1);
    check("t5_addr16", laddr[1], 16'h3008);
    check("t5_reg_addr16", raddr[1], 16'h3008);
    check("t5_addr_mode", am[1], 1);
    check("t5_done", done[1], 1);
    check("t5_err", err[1], 0);

    rd_xor[1] = 8'hFF;
    rom[1][0] = 24'h001280;
    w0 = wcnt[1];
    r0 = rcnt[1];
    pulse(1, s);
    wait_idle(1);
    check("t6_writes", wcnt[1] - w0, 4);
    check("t6_reads", rcnt[1] - r0, 4);
    check("t6_err", err[1], 1);
    check("t6_err_index", erri[1], 0);
    check("t6_done", done[1], 0);

    rom[0][0] = 24'h001280; rom[0][1] = 24'h001355; rom[0][2] = 24'hFFFE00;
    lat[0] = 10;
    w0 = wcnt[0];
    pulse(0, s);
    wait_first(0, w0, fw);
    repeat (3) @(negedge clk);
    pulse(0, s);
    check("t7_rstn_low", rstn[0], 0);
    check("t7_pwdn_high", pwdn[0], 1);
    check("t7_taddr0", taddr[0], 0);
    check("t7_busy", busy[0], 1);
    w0 = wcnt[0];
    wait_first(0, w0, fw);
    check("t7_first_wr", fw - s, 62);
    wait_idle(0);
    check("t7_writes", wcnt[0] - w0, 2);
    check("t7_done", done[0], 1);
    check("t7_err", err[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
